// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment decode table for the seven-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, 1 = segment lit.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h00;

    // Entry n sits at bits [7n +: 7]; lowercase glyphs keep b and d distinct from 8 and 0.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic seg7_t seg7_decode(input logic [3:0] nib);
        return SEG7_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_refresh_prescaler.sv
// Digit-slot timebase: counts 0..DIV-1 and flags the last cycle of each slot.
module seg7_refresh_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment bank driver with frame-synchronous value update and leading-zero blanking.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
`ifdef SEG7_BLINK_EN
    parameter int BLINK_FRAMES   = 64,
`endif
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? ~SEG7_BLANK : SEG7_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic                    tick;
    logic                    wrap;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    all_zero;
    logic                    blink_blank;
    seg7_t                   seg_on;
    logic [NUM_DIGITS-1:0]   an_on;

    seg7_refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        idx_d = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    // A load on the wrap cycle bypasses the shadow so it lands in the frame starting now.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (wrap) begin
            if (load_i)         active_d = value_i;
            else if (pending_q) active_d = shadow_q;
            pending_d = 1'b0;
        end else if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (active_d[4*k +: 4] == 4'h0);
            if (k != 0) lz_mask[k] = all_zero && blank_lz_i;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BF_W-1:0] bcnt_q, bcnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_blank = phase_d && blink_mask_i[idx_d];
`else
    assign blink_blank = 1'b0;
`endif

    // Output registers are fed from next-state values so a digit appears the cycle after its tick.
    always_comb begin
        seg_on = seg7_decode(active_d[4*idx_d +: 4]);
        if (lz_mask[idx_d] || blink_blank) seg_on = SEG7_BLANK;
        seg_d = (ACTIVE_LOW_SEG != 0) ? ~seg_on : seg_on;
        an_on = '0;
        an_on[idx_d] = 1'b1;
        an_d = (ACTIVE_LOW_AN != 0) ? ~an_on : an_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = tick ? AN_OFF : an_q;
    assign frame_o = wrap;

endmodule
